// File: rtl/tone_pkg.sv
// Shared FSM state type and default tuning constants for the tone period detector.
package tone_pkg;

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEF_HYST       = 8;
  localparam int DEF_AVG_LOG2   = 2;
  localparam int DEF_MIN_PERIOD = 4;
  localparam int DEF_MAX_PERIOD = 4095;
  localparam int DEF_PERIOD_W   = 16;

endpackage

// File: rtl/zc_schmitt.sv
// Schmitt-trigger zero-crossing detector: holds the level bit and flags a rising
// crossing combinationally in the same cycle as the qualifying sample strobe.
module zc_schmitt
  import tone_pkg::*;
#(
  parameter int HYST = DEF_HYST
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic signed [7:0] i_amp,
  output logic              o_rise
);

  localparam logic signed [7:0] HI_THRESH = 8'(HYST);
  localparam logic signed [7:0] LO_THRESH = 8'(-HYST);

  logic r_lvl;
  logic w_goHigh;
  logic w_goLow;

  assign w_goHigh = i_step && !r_lvl && (i_amp >= HI_THRESH);
  assign w_goLow  = i_step &&  r_lvl && (i_amp <= LO_THRESH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lvl <= 1'b0;
    end else if (w_goHigh) begin
      r_lvl <= 1'b1;
    end else if (w_goLow) begin
      r_lvl <= 1'b0;
    end
  end

  assign o_rise = w_goHigh;

endmodule

// File: rtl/tone_period_detector.sv
// Measures the period of a sampled tone between rising Schmitt crossings and
// publishes the mean of 2^AVG_LOG2 consecutive accepted periods.
module tone_period_detector
  import tone_pkg::*;
#(
  parameter int HYST       = DEF_HYST,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int PERIOD_W   = DEF_PERIOD_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                step_in,
  input  logic signed [7:0]   amp_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic                valid_out,
  output logic                tone_present_out
);

  localparam int ACC_W = PERIOD_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [N_W-1:0]      N_FULL  = N_W'(1 << AVG_LOG2);
  localparam logic [PERIOD_W-1:0] P_MIN   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] P_MAX   = PERIOD_W'(MAX_PERIOD);

  state_t              r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [N_W-1:0]      r_n;
  logic [PERIOD_W-1:0] r_period;
  logic                r_valid;
  logic                r_tone;

  logic                w_rise;
  logic [PERIOD_W-1:0] w_p;
  logic [ACC_W-1:0]    w_sum;
  logic [PERIOD_W-1:0] w_avg;
  logic [N_W-1:0]      w_nNext;

  zc_schmitt #(
    .HYST (HYST)
  ) u_schmitt (
    .i_clk  (clk_in),
    .i_rst  (rst_in),
    .i_step (step_in),
    .i_amp  (amp_in),
    .o_rise (w_rise)
  );

  assign w_p     = r_cnt + PERIOD_W'(1);
  assign w_sum   = r_acc + ACC_W'(w_p);
  assign w_avg   = PERIOD_W'(w_sum >> AVG_LOG2);
  assign w_nNext = r_n + N_W'(1);

  // Counter never exceeds MAX_PERIOD-1, so an accepted period is always <= MAX_PERIOD.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= SYNC;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_n      <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_tone   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (step_in) begin
        case (r_state)
          SYNC: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_n     <= '0;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_cnt <= '0;
              if (w_p < P_MIN) begin
                r_acc <= '0;
                r_n   <= '0;
              end else if (w_nNext == N_FULL) begin
                r_period <= w_avg;
                r_valid  <= 1'b1;
                r_tone   <= 1'b1;
                r_acc    <= '0;
                r_n      <= '0;
              end else begin
                r_acc <= w_sum;
                r_n   <= w_nNext;
              end
            end else if (w_p == P_MAX) begin
              r_state <= SYNC;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_n     <= '0;
              r_tone  <= 1'b0;
            end else begin
              r_cnt <= w_p;
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign period_out       = r_period;
  assign valid_out        = r_valid;
  assign tone_present_out = r_tone;

endmodule

// File: tb/tb_tone_period_detector.sv
// Directed bench: a sample-level reference model feeds a scoreboard of expected
// periods, plus fixed expectations from known tone frequencies.
module tb_tone_period_detector;

  localparam int HYST       = 8;
  localparam int AVG_LOG2   = 2;
  localparam int MIN_PERIOD = 4;
  localparam int MAX_PERIOD = 4095;
  localparam int PERIOD_W   = 16;
  localparam bit [31:0] INC750 = 32'h1000_0000;
  localparam bit [31:0] INC440 = 32'h0963_3A1B;
  localparam real PI = 3.14159265358979;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                step_in;
  logic signed [7:0]   amp_in;
  logic [PERIOD_W-1:0] period_out;
  logic                valid_out;
  logic                tone_present_out;

  always #5 clk_in = ~clk_in;

  tone_period_detector #(
    .HYST       (HYST),
    .AVG_LOG2   (AVG_LOG2),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD),
    .PERIOD_W   (PERIOD_W)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .step_in          (step_in),
    .amp_in           (amp_in),
    .period_out       (period_out),
    .valid_out        (valid_out),
    .tone_present_out (tone_present_out)
  );

  int checks = 0;
  int errors = 0;
  int expQ[$];

  bit mLvl, mMeasure, mTone, mValid, mRise;
  int mCnt, mAcc, mN, mPeriod;

  int riseCount, validCount, sampleIdx, sinceRise, expConst;
  bit [31:0] phase;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLvl = 0; mMeasure = 0; mTone = 0; mValid = 0; mRise = 0;
    mCnt = 0; mAcc = 0; mN = 0; mPeriod = 0;
    expQ.delete();
  endtask

  task automatic modelStep(input int amp);
    int p;
    mValid = 0;
    mRise  = !mLvl && (amp >= HYST);
    if (mRise) mLvl = 1;
    else if (mLvl && amp <= -HYST) mLvl = 0;
    p = mCnt + 1;
    if (!mMeasure) begin
      if (mRise) begin
        mMeasure = 1; mCnt = 0; mAcc = 0; mN = 0;
      end
    end else if (mRise) begin
      mCnt = 0;
      if (p < MIN_PERIOD) begin
        mAcc = 0; mN = 0;
      end else if (mN + 1 == (1 << AVG_LOG2)) begin
        mPeriod = (mAcc + p) >> AVG_LOG2;
        mValid = 1; mTone = 1; mAcc = 0; mN = 0;
        expQ.push_back(mPeriod);
      end else begin
        mAcc += p; mN++;
      end
    end else if (p == MAX_PERIOD) begin
      mMeasure = 0; mCnt = 0; mAcc = 0; mN = 0; mTone = 0;
    end else begin
      mCnt = p;
    end
  endtask

  // Drive one sample at a negedge, then check the registered result one edge later.
  task automatic applyStimulus(input int amp, input int gap);
    int got;
    step_in = 1'b1;
    amp_in  = 8'(amp);
    modelStep(amp);
    @(negedge clk_in);
    step_in = 1'b0;
    sampleIdx++;
    if (mRise) begin riseCount++; sinceRise = 0; end
    else sinceRise++;
    checkOutput("valid", {31'd0, valid_out}, {31'd0, mValid});
    checkOutput("tone", {31'd0, tone_present_out}, {31'd0, mTone});
    checkOutput("period", 32'(period_out), 32'(mPeriod));
    if (valid_out === 1'b1) begin
      validCount++;
      checkOutput("sb_pending", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        got = expQ.pop_front();
        checkOutput("sb_period", 32'(period_out), 32'(got));
      end
      if (expConst >= 0) checkOutput("fixed_period", 32'(period_out), 32'(expConst));
    end
    for (int g = 1; g < gap; g++) begin
      @(negedge clk_in);
      if (g == 1) checkOutput("valid_pulse", {31'd0, valid_out}, 32'd0);
    end
  endtask

  task automatic toneSample(input bit [31:0] inc, input int shift, input int gap);
    int s;
    s = int'(127.0 * $sin(2.0 * PI * real'(phase) / 4294967296.0));
    s = s >>> shift;
    applyStimulus(s, gap);
    phase += inc;
  endtask

  task automatic plainReset();
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    modelReset();
  endtask

  task automatic runUntilValid(input bit [31:0] inc, input int gap, input int limit);
    for (int i = 0; i < limit && validCount == 0; i++) toneSample(inc, 0, gap);
    checkOutput("valid_seen", 32'(validCount), 32'd1);
  endtask

  initial begin
    int idx1;
    rst_in = 1'b1; step_in = 1'b0; amp_in = '0;
    riseCount = 0; validCount = 0; sampleIdx = 0; sinceRise = 0; expConst = -1;
    modelReset();
    repeat (3) @(negedge clk_in);
    checkOutput("rst_period", 32'(period_out), 32'd0);
    checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("rst_tone", {31'd0, tone_present_out}, 32'd0);
    rst_in = 1'b0;

    $display("[TB] 750 Hz lock");
    phase = 0; expConst = 16;
    runUntilValid(INC750, 4, 200);
    checkOutput("t1_rises", 32'(riseCount), 32'd5);
    checkOutput("t1_period", 32'(period_out), 32'd16);
    checkOutput("t1_tone", {31'd0, tone_present_out}, 32'd1);
    idx1 = sampleIdx;
    for (int i = 0; i < 200 && validCount < 2; i++) toneSample(INC750, 0, 4);
    checkOutput("t1_interval", 32'(sampleIdx - idx1), 32'd64);

    $display("[TB] timeout on silence");
    for (int i = 0; i < 5000 && tone_present_out === 1'b1; i++) applyStimulus(0, 1);
    checkOutput("t2_timeout_at", 32'(sinceRise), 32'(MAX_PERIOD));
    checkOutput("t2_hold", 32'(period_out), 32'd16);
    checkOutput("t2_tone", {31'd0, tone_present_out}, 32'd0);
    phase = 0; riseCount = 0; validCount = 0;
    runUntilValid(INC750, 4, 200);
    checkOutput("t2_resume_rises", 32'(riseCount), 32'd5);

    $display("[TB] 440 Hz");
    plainReset();
    phase = 0; validCount = 0; expConst = 27;
    for (int i = 0; i < 400; i++) toneSample(INC440, 0, 1);
    checkOutput("t3_valids", 32'(validCount >= 2), 32'd1);

    $display("[TB] 440 Hz below hysteresis");
    plainReset();
    phase = 0; validCount = 0; expConst = -1;
    for (int i = 0; i < 300; i++) toneSample(INC440, 4, 1);
    checkOutput("t4_valids", 32'(validCount), 32'd0);
    checkOutput("t4_tone", {31'd0, tone_present_out}, 32'd0);

    $display("[TB] glitch rejection");
    plainReset();
    validCount = 0;
    for (int i = 0; i < 40; i++) applyStimulus((i % 2 == 0) ? 100 : -100, 1);
    checkOutput("t5_valids", 32'(validCount), 32'd0);
    phase = 0; expConst = 16;
    runUntilValid(INC750, 4, 200);
    checkOutput("t5_period", 32'(period_out), 32'd16);

    $display("[TB] reset with strobe mid-window");
    for (int i = 0; i < 60 && (i < 20 || phase[31:28] != 4'd12); i++) toneSample(INC750, 0, 4);
    step_in = 1'b1; rst_in = 1'b1; amp_in = -8'sd100;
    @(negedge clk_in);
    step_in = 1'b0; rst_in = 1'b0;
    phase += INC750;
    modelReset();
    checkOutput("t6_period", 32'(period_out), 32'd0);
    checkOutput("t6_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("t6_tone", {31'd0, tone_present_out}, 32'd0);
    riseCount = 0; validCount = 0;
    runUntilValid(INC750, 4, 200);
    checkOutput("t6_rises", 32'(riseCount), 32'd5);
    checkOutput("t6_final_period", 32'(period_out), 32'd16);

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_period_detector.md
# tone_period_detector

Pitch-measurement front end for the transcription path. Consumes a stream of signed 8-bit audio samples, one per `step_in` strobe, the same sample format and rate as the on-chip sine generators. Detects rising zero crossings through a Schmitt trigger and measures the period in samples. Publishes a period averaged over 2^AVG_LOG2 cycles for the downstream note classifier.

## Interface
- `HYST`, default 8: Schmitt threshold; input must reach `>= +HYST` to go high and `<= -HYST` to go low.
- `AVG_LOG2`, default 2: average over 4 periods.
- `MIN_PERIOD`, default 4: shortest accepted period, in samples.
- `MAX_PERIOD`, default 4095: longest accepted period; also the timeout.
- `PERIOD_W`, default 16: width of `period_out`; MAX_PERIOD < 2^PERIOD_W.
- `clk_in`, input, 1: system clock; the only clock.
- `rst_in`, input, 1: synchronous, active-high reset.
- `step_in`, input, 1: sample strobe; `amp_in` is valid only when this is high.
- `amp_in`, input, 8: signed two's-complement sample.
- `period_out`, output, PERIOD_W: averaged period in samples; holds its value between updates.
- `valid_out`, output, 1: one-cycle pulse when `period_out` updates.
- `tone_present_out`, output, 1: high while a periodic tone is being tracked.

## Operation
- Schmitt level bit `lvl`, reset to LOW.
  - LOW→HIGH when `step_in && amp_in >= HYST`. This is a rising event.
  - HIGH→LOW when `step_in && amp_in <= -HYST`.
  - `lvl` tracks the input in every state.
- Sample counter `cnt` (PERIOD_W bits). On each `step_in`, candidate period `p = cnt+1`.
- FSM states:
  - SYNC: reset state. A rising event sets `cnt<=0`, `n<=0`, `acc<=0` and moves to MEASURE. Any other `step_in` is ignored.
  - MEASURE, on a rising event:
    - `MIN_PERIOD <= p <= MAX_PERIOD`: add `p` to `acc` (PERIOD_W+AVG_LOG2 bits, no overflow possible); `n<=n+1`; `cnt<=0`.
    - `p < MIN_PERIOD`: glitch. Clear `acc` and `n`, set `cnt<=0`, stay in MEASURE. `tone_present_out` is unchanged.
  - MEASURE, on `step_in` without a rising event:
    - `p == MAX_PERIOD`: timeout. Go to SYNC, clear `acc` and `n`, set `tone_present_out<=0`. `period_out` holds.
    - Otherwise `cnt<=p`.
- Averaging: when the accepted period makes `n` reach 2^AVG_LOG2:
  - `period_out <= (acc+p) >> AVG_LOG2` (truncating).
  - `valid_out<=1`, `tone_present_out<=1`.
  - Clear `acc` and `n`; the next window starts at this same crossing.
- A rising event at exactly `p == MAX_PERIOD` counts as a crossing (accepted), not a timeout.
- `step_in` low: no state changes except that `valid_out` returns to 0.

## Timing
- Reset values: `period_out=0`, `valid_out=0`, `tone_present_out=0`, state SYNC, `lvl=LOW`, `cnt=acc=n=0`.
- `rst_in` wins over `step_in` in the same cycle; that sample is discarded.
- Reset mid-measurement discards all partial results.
- Latency: the result of a `step_in` in cycle N appears in registers in cycle N+1. `valid_out` is high only in N+1.
- The first `valid_out` after SYNC requires 2^AVG_LOG2+1 rising events.
- `step_in` may be asserted every cycle; there is no backpressure.

## Structure
- Package `tone_pkg`: state enum `{SYNC, MEASURE}`, default constants for HYST, AVG_LOG2, MIN_PERIOD, MAX_PERIOD, PERIOD_W.
- Sub-module `zc_schmitt`: holds `lvl` and produces a one-cycle `rise` pulse, qualified by `step_in`.
- Counter, accumulator and FSM live in the top module.

## Test plan
- 750 Hz tone, 16 samples/period, full-scale ±127, `step_in` every 4 clocks:
  - first `valid_out` on the 5th rising event, `period_out=16`, `tone_present_out=1`;
  - after that, one `valid_out` every 64 samples.
- 440 Hz tone at 12 kHz, phase increment 0x09633A1B, full scale:
  - periods are 27 or 28 samples;
  - every `period_out` is 27.
- Same 440 Hz tone arithmetically shifted right by 4 (peak +7 < HYST=8):
  - no `valid_out`, `tone_present_out` stays 0.
- Lock on 750 Hz, then feed zeros:
  - `tone_present_out` falls at the 4095th sample after the last rising event;
  - `period_out` holds 16;
  - resuming the tone gives a new `valid_out` after 5 crossings.
- Alternating +100/−100 every sample (p=2 < MIN_PERIOD):
  - no `valid_out`;
  - switching to 750 Hz yields `period_out=16` after 4 accepted periods.
- Assert `rst_in` together with `step_in` mid-window:
  - all outputs 0 the next cycle;
  - the next `valid_out` arrives only after 5 fresh crossings.
